// File: rtl/bp_pkg.sv
// Shared types for the 1-bit branch predictor: table index width and index type,
// used by the predictor table, the fetch-side lookup and the resolution comparator.
package bp_pkg;

   localparam int BP_AW = 3;

   typedef logic [BP_AW-1:0] bp_idx_t;

   // A branch was mispredicted when the resolved direction differs from the guess.
   function automatic logic bp_miss(input logic outcome, input logic prediction);
      return outcome ^ prediction;
   endfunction

endpackage

// File: rtl/comparator.sv
// Resolution-stage misprediction check: registers OUTCOME^PREDICTION as MISS and forwards
// the branch's table index as ADDR_W so the table can be rewritten with OUTCOME on a miss.
module comparator
   import bp_pkg::*;
#(
   parameter int AW = BP_AW
) (
   input  logic          CLOCK,
   input  logic          INIT,
   input  logic          OUTCOME,
   input  logic [AW-1:0] ADDR,
   input  logic          PREDICTION,
   output logic [AW-1:0] ADDR_W,
   output logic          MISS
);

   logic miss_d;

   // No valid qualifier: a comparison is made every cycle. Inputs are not masked,
   // so an X on OUTCOME/PREDICTION/ADDR shows up on the registered outputs.
   assign miss_d = bp_miss(OUTCOME, PREDICTION);

   always_ff @(posedge CLOCK or posedge INIT) begin
      if (INIT) begin
         MISS   <= 1'b0;
         ADDR_W <= '0;
      end else begin
         MISS   <= miss_d;
         ADDR_W <= ADDR;
      end
   end

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for the branch misprediction comparator: directed cases, reset
// behaviour and a randomized run against a cycle-delay reference model.
module tb_comparator;
   import bp_pkg::*;

   localparam int AW = BP_AW;

   logic          clock;
   logic          init;
   logic          outcome;
   logic [AW-1:0] addr;
   logic          prediction;
   logic [AW-1:0] addr_w;
   logic          miss;

   int vectors;
   int miscompares;

   // Expected {miss, addr_w} for each edge, pushed when inputs are applied.
   logic [AW:0] exp_q[$];

   comparator #(.AW(AW)) dut (
      .CLOCK      (clock),
      .INIT       (init),
      .OUTCOME    (outcome),
      .ADDR       (addr),
      .PREDICTION (prediction),
      .ADDR_W     (addr_w),
      .MISS       (miss)
   );

   // Clock / reset block: 10 time-unit period, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference: a branch is mispredicted exactly when the two directions disagree.
   function automatic logic ref_miss(input logic o, input logic p);
      return (o == p) ? 1'b0 : 1'b1;
   endfunction

   // Driver: apply inputs mid-cycle, then check one edge later.
   task automatic step(input logic o, input logic p, input logic [AW-1:0] a, input string name);
      logic [AW:0] exp;
      @(negedge clock);
      outcome    = o;
      prediction = p;
      addr       = a;
      exp_q.push_back({ref_miss(o, p), a});
      @(posedge clock);
      #1;
      exp = exp_q.pop_front();
      vectors++;
      if (miss !== exp[AW]) begin
         miscompares++;
         $display("FAIL %s miss: got %b expected %b (o=%b p=%b)", name, miss, exp[AW], o, p);
      end
      vectors++;
      if (addr_w !== exp[AW-1:0]) begin
         miscompares++;
         $display("FAIL %s addr_w: got %0d expected %0d", name, addr_w, exp[AW-1:0]);
      end
   endtask

   task automatic check_clear(input string name);
      vectors++;
      if (miss !== 1'b0) begin
         miscompares++;
         $display("FAIL %s miss: got %b expected 0", name, miss);
      end
      vectors++;
      if (addr_w !== '0) begin
         miscompares++;
         $display("FAIL %s addr_w: got %0d expected 0", name, addr_w);
      end
   endtask

   task automatic test_reset();
      init       = 1'b0;
      outcome    = 1'b0;
      prediction = 1'b0;
      addr       = '0;
      #15;
      init = 1'b1;
      #5;
      check_clear("reset_during");
      #5;
      init = 1'b0;
      #5;
      check_clear("reset_after");
   endtask

   task automatic test_truth_table();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, AW'(i), "hold_00");
      step(1'b1, 1'b0, 3'd2, "tt_10");
      step(1'b0, 1'b1, 3'd4, "tt_01");
      step(1'b0, 1'b0, 3'd1, "tt_00");
      step(1'b1, 1'b1, 3'd7, "tt_11");
      step(1'b1, 1'b0, 3'd5, "miss_addr5");
   endtask

   task automatic test_mid_reset();
      logic [AW:0] exp;
      // Previous step left MISS=1, ADDR_W=5; we are 1 unit past the edge.
      #1;
      init = 1'b1;
      #1;
      check_clear("async_clear");
      outcome    = 1'b1;
      prediction = 1'b0;
      addr       = 3'd6;
      exp_q.push_back({ref_miss(1'b1, 1'b0), 3'd6});
      #1;
      init = 1'b0;
      #1;
      check_clear("release_no_capture");
      @(posedge clock);
      #1;
      exp = exp_q.pop_front();
      vectors++;
      if (miss !== exp[AW]) begin
         miscompares++;
         $display("FAIL first_capture miss: got %b expected %b", miss, exp[AW]);
      end
      vectors++;
      if (addr_w !== exp[AW-1:0]) begin
         miscompares++;
         $display("FAIL first_capture addr_w: got %0d expected %0d", addr_w, exp[AW-1:0]);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) step(i[0], ~i[0], AW'(7 - i), "b2b_alt");
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, (1 << AW) - 1)), "random");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_truth_table();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
